regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-port integer register file with write-first bypass and a per-register scoreboard, replacing the fixed 2-read/1-write 32x32 file in the RISC-V core. Decode reads operands and busy status through NUM_RD read ports. Up to NUM_WR writeback ports commit results. An issue port marks destination registers busy until their result is written back. Register 0 is optionally hardwired to zero.

## Interface
Parameters:
- ADDR_W, 5, register address width; depth DEPTH = 2**ADDR_W
- DATA_W, 32, register data width
- NUM_RD, 2, number of read ports (1..4)
- NUM_WR, 2, number of write ports (1..2)
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and is never busy

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  global write/issue enable; reads are unaffected
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port p at [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port p at [p*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  scoreboard busy for each read address
- wr_en  in  NUM_WR  write strobe per writeback port
- wr_addr  in  NUM_WR*ADDR_W  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- iss_en  in  1  issue strobe: mark iss_addr busy
- iss_addr  in  ADDR_W  destination register of issued instruction
- busy_cnt  out  ADDR_W+1  registered count of busy registers
- wr_conflict  out  1  sticky flag: two write ports hit the same address in one cycle

## Operation
- Reset (rst_n low, asynchronous): all registers 0, all busy bits 0, busy_cnt 0, wr_conflict 0. While reset is held, rd_data = 0 and rd_busy = 0.
- Effective write on port w: wr_en[w] & enable & !(ZERO_REG & wr_addr[w]==0).
- Commit: each effective write updates mem[wr_addr[w]] on the rising clk edge.
  - If both ports write the same address, port NUM_WR-1 wins.
  - wr_conflict is set on that edge and stays set until reset.
- Read port p, combinational, in priority order:
  - ZERO_REG & addr 0 -> 0.
  - Else, if an effective write targets rd_addr[p] this cycle -> that wr_data (highest-index port wins).
  - Else -> mem[rd_addr[p]].
- Scoreboard: busy[DEPTH] register bits.
  - Effective issue: iss_en & enable & !(ZERO_REG & iss_addr==0); sets busy[iss_addr] on the edge.
  - Effective write clears busy[wr_addr] on the edge.
  - Issue and write to the same address in the same cycle: the issue wins, and the bit ends up set. This is a new producer, so the old result commits but the register stays busy.
- rd_busy[p] = busy[rd_addr[p]] & !(effective write to rd_addr[p] this cycle) | 0 for the zero register.
  - A same-cycle issue does not affect rd_busy until the next cycle.
- busy_cnt: the population count of busy after each edge, updated in the same edge as busy. Range 0..DEPTH-ZERO_REG.
- A write to a non-busy register is legal. It updates the data and leaves busy at 0.
- enable low: no commits, no issues, no bypass, no conflict detection. Read ports still return stored values and busy bits.

## Timing
- Read latency 0: rd_data and rd_busy are combinational from addresses, writes and state.
- Write latency 1: committed data is visible from storage one cycle after the write cycle, and via bypass in the write cycle itself.
- Busy set latency 1: issue in cycle N -> rd_busy high from cycle N+1.
- Busy clear: writeback in cycle N -> rd_busy low in cycle N (bypass) and after.
- busy_cnt and wr_conflict change only on clk edges or on reset assertion.
- Reset may assert mid-operation. All state clears immediately, and an in-flight write in that cycle is lost.
- Deassertion of rst_n is assumed synchronised upstream; the first edge after deassertion is a normal cycle.

## Test plan
- Reset: load nonzero values, pulse rst_n low mid-cycle -> all rd_data 0, rd_busy 0, busy_cnt 0, wr_conflict 0 immediately.
- Bypass: write port 0 addr 5 = 0xDEADBEEF with rd_addr port 1 = 5 in the same cycle -> rd_data port 1 = 0xDEADBEEF that cycle and persists after.
- Zero register: write addr 0 = 0x1234 and issue addr 0 -> read 0 returns 0, rd_busy 0, busy_cnt unchanged.
- Scoreboard: issue addr 7 at cycle N -> rd_busy high at N+1, busy_cnt 1.
  - Write addr 7 = 0x55 at N+3 -> rd_busy low and rd_data 0x55 at N+3, busy_cnt 0 at N+4.
- Same-cycle issue and write on addr 9 (busy) -> data updated, busy stays 1, busy_cnt unchanged.
- Write conflict: both ports write addr 3 (0xA, 0xB) -> read returns 0xB, wr_conflict 1 and sticky.
- enable low: both writes and an issue to addr 4 -> mem[4], busy[4], busy_cnt and wr_conflict all unchanged.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Register file bus: read, writeback, issue and status signals
// bundled between decode/writeback (master) and the file (slave).
interface regfile_sb_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) ();
  logic                     enable;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic [ADDR_W:0]          busy_cnt;
  logic                     wr_conflict;

  modport master (
    output enable, rd_addr, wr_en, wr_addr,
    output wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, busy_cnt, wr_conflict
  );

  modport slave (
    input  enable, rd_addr, wr_en, wr_addr,
    input  wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, busy_cnt, wr_conflict
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port integer register file with write-first bypass
// and a per-register busy scoreboard.
module regfile_sb #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  regfile_sb_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [ADDR_W:0]   r_busy_cnt;
  logic              r_conflict;

  logic [NUM_WR-1:0] w_wen;
  logic [ADDR_W-1:0] w_waddr [NUM_WR];
  logic [DATA_W-1:0] w_wdata [NUM_WR];
  logic              w_iss;
  logic              w_conf;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic [ADDR_W:0]   w_cnt_nxt;

  always_comb begin
    for (int w = 0; w < NUM_WR; w++) begin
      w_waddr[w] = bus.wr_addr[w*ADDR_W +: ADDR_W];
      w_wdata[w] = bus.wr_data[w*DATA_W +: DATA_W];
      w_wen[w]   = bus.wr_en[w] & bus.enable &
                   !(ZR && w_waddr[w] == '0);
    end
    w_iss = bus.iss_en & bus.enable &
            !(ZR && bus.iss_addr == '0);
  end

  always_comb begin
    w_conf = 1'b0;
    for (int i = 0; i < NUM_WR; i++)
      for (int j = i + 1; j < NUM_WR; j++)
        if (w_wen[i] && w_wen[j] &&
            w_waddr[i] == w_waddr[j])
          w_conf = 1'b1;
  end

  // Issue is applied after the clears: a new producer keeps it busy.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int w = 0; w < NUM_WR; w++)
      if (w_wen[w]) w_busy_nxt[w_waddr[w]] = 1'b0;
    if (w_iss) w_busy_nxt[bus.iss_addr] = 1'b1;
    w_cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      w_cnt_nxt = w_cnt_nxt +
                  {{ADDR_W{1'b0}}, w_busy_nxt[i]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++)
        if (w_wen[w]) r_mem[w_waddr[w]] <= w_wdata[w];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
      if (w_conf) r_conflict <= 1'b1;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              b;
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      a = bus.rd_addr[p*ADDR_W +: ADDR_W];
      d = r_mem[a];
      b = r_busy[a];
      for (int w = 0; w < NUM_WR; w++)
        if (w_wen[w] && w_waddr[w] == a) begin
          d = w_wdata[w];
          b = 1'b0;
        end
      if (!rst_n || (ZR && a == '0)) begin
        d = '0;
        b = 1'b0;
      end
      bus.rd_data[p*DATA_W +: DATA_W] = d;
      bus.rd_busy[p] = b;
    end
  end

  assign bus.busy_cnt    = r_busy_cnt;
  assign bus.wr_conflict = r_conflict;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: bypass, zero reg,
// scoreboard, conflicts, enable gating and async reset.
module tb_regfile_sb;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  regfile_sb_if #(
    .ADDR_W(5), .DATA_W(32), .NUM_RD(2), .NUM_WR(2)
  ) bus ();

  regfile_sb #(
    .ADDR_W(5), .DATA_W(32), .NUM_RD(2),
    .NUM_WR(2), .ZERO_REG(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en  = '0;
    bus.iss_en = 1'b0;
  endtask

  task automatic wr(int p, logic [4:0] a,
                    logic [31:0] d);
    bus.wr_en[p]          = 1'b1;
    bus.wr_addr[p*5 +: 5] = a;
    bus.wr_data[p*32 +: 32] = d;
  endtask

  task automatic iss(logic [4:0] a);
    bus.iss_en   = 1'b1;
    bus.iss_addr = a;
  endtask

  task automatic rd(logic [4:0] a0, logic [4:0] a1);
    bus.rd_addr = {a1, a0};
  endtask

  function automatic logic [31:0] rdat(int p);
    return bus.rd_data[p*32 +: 32];
  endfunction

  function automatic logic [31:0] rbsy(int p);
    return {31'd0, bus.rd_busy[p]};
  endfunction

  function automatic logic [31:0] cnt();
    return {26'd0, bus.busy_cnt};
  endfunction

  function automatic logic [31:0] conf();
    return {31'd0, bus.wr_conflict};
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.enable   = 1'b1;
    bus.rd_addr  = '0;
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.iss_en   = 1'b0;
    bus.iss_addr = '0;
    step();
    step();
    rst_n = 1'b1;
    rd(5'd5, 5'd6);
    #1;
    chk("rst_cnt", cnt(), 32'd0);
    chk("rst_conf", conf(), 32'd0);
    chk("rst_rd0", rdat(0), 32'd0);
    chk("rst_bsy0", rbsy(0), 32'd0);

    // bypass in the write cycle, storage afterwards
    step();
    wr(0, 5'd5, 32'hDEADBEEF);
    rd(5'd0, 5'd5);
    #1;
    chk("byp_rd1", rdat(1), 32'hDEADBEEF);
    chk("byp_bsy1", rbsy(1), 32'd0);
    step();
    idle();
    #1;
    chk("byp_mem1", rdat(1), 32'hDEADBEEF);

    // zero register
    wr(0, 5'd0, 32'h1234);
    iss(5'd0);
    rd(5'd0, 5'd0);
    #1;
    chk("z_rd0", rdat(0), 32'd0);
    chk("z_bsy0", rbsy(0), 32'd0);
    step();
    idle();
    #1;
    chk("z_cnt", cnt(), 32'd0);
    chk("z_rd0b", rdat(0), 32'd0);
    chk("z_bsyb", rbsy(0), 32'd0);

    // scoreboard on addr 7
    iss(5'd7);
    rd(5'd7, 5'd0);
    #1;
    chk("sb_bsyN", rbsy(0), 32'd0);
    step();
    idle();
    #1;
    chk("sb_bsyN1", rbsy(0), 32'd1);
    chk("sb_cntN1", cnt(), 32'd1);
    step();
    chk("sb_bsyN2", rbsy(0), 32'd1);
    step();
    wr(1, 5'd7, 32'h55);
    #1;
    chk("sb_bsyN3", rbsy(0), 32'd0);
    chk("sb_rdN3", rdat(0), 32'h55);
    chk("sb_cntN3", cnt(), 32'd1);
    step();
    idle();
    #1;
    chk("sb_cntN4", cnt(), 32'd0);
    chk("sb_bsyN4", rbsy(0), 32'd0);
    chk("sb_rdN4", rdat(0), 32'h55);

    // issue + write same cycle on busy addr 9
    iss(5'd9);
    step();
    idle();
    rd(5'd9, 5'd0);
    #1;
    chk("i9_cnt", cnt(), 32'd1);
    chk("i9_bsy", rbsy(0), 32'd1);
    iss(5'd9);
    wr(0, 5'd9, 32'h99);
    #1;
    chk("i9w_rd", rdat(0), 32'h99);
    chk("i9w_bsy", rbsy(0), 32'd0);
    step();
    idle();
    #1;
    chk("i9w_bsy2", rbsy(0), 32'd1);
    chk("i9w_cnt2", cnt(), 32'd1);
    chk("i9w_rd2", rdat(0), 32'h99);

    // write conflict on addr 3
    wr(0, 5'd3, 32'hA);
    wr(1, 5'd3, 32'hB);
    rd(5'd0, 5'd3);
    #1;
    chk("cf_byp", rdat(1), 32'hB);
    chk("cf_pre", conf(), 32'd0);
    step();
    idle();
    #1;
    chk("cf_set", conf(), 32'd1);
    chk("cf_mem", rdat(1), 32'hB);
    step();
    chk("cf_stk", conf(), 32'd1);

    // enable low gates writes, issues, bypass
    bus.enable = 1'b0;
    wr(0, 5'd4, 32'h44);
    wr(1, 5'd4, 32'h45);
    iss(5'd4);
    rd(5'd4, 5'd9);
    #1;
    chk("en_byp", rdat(0), 32'd0);
    chk("en_bsy9", rbsy(1), 32'd1);
    chk("en_rd9", rdat(1), 32'h99);
    step();
    idle();
    bus.enable = 1'b1;
    #1;
    chk("en_mem4", rdat(0), 32'd0);
    chk("en_bsy4", rbsy(0), 32'd0);
    chk("en_cnt", cnt(), 32'd1);
    chk("en_conf", conf(), 32'd1);

    // async reset mid-cycle with a write in flight
    wr(0, 5'd10, 32'h77);
    rd(5'd9, 5'd10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_rd9", rdat(0), 32'd0);
    chk("ar_bsy9", rbsy(0), 32'd0);
    chk("ar_rd10", rdat(1), 32'd0);
    chk("ar_cnt", cnt(), 32'd0);
    chk("ar_conf", conf(), 32'd0);
    step();
    idle();
    rst_n = 1'b1;
    rd(5'd5, 5'd10);
    #1;
    chk("ar_mem5", rdat(0), 32'd0);
    chk("ar_mem10", rdat(1), 32'd0);
    step();
    chk("ar_cnt2", cnt(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
